// File: rtl/nv_ctrl_pkg.sv
// Shared NV controller definitions used by the serializer and deserializer.
package nv_ctrl_pkg;

    localparam int NV_DATA_WIDTH = 8;
    localparam int NV_LSB_FIRST  = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/nv_rx_shift_reg.sv
// Receive shift register and bit counter; presents the completed word in the
// same cycle that its last bit arrives.
module nv_rx_shift_reg
    import nv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = NV_DATA_WIDTH,
    parameter int LSB_FIRST  = NV_LSB_FIRST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  serial_data_in,
    output logic                  word_done,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        bit_idx = (LSB_FIRST != 0) ? bit_cnt_q : (LAST_BIT - bit_cnt_q);
        // Incoming bit merged combinationally so the word is whole on its last edge
        word = shreg_q;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            if (bit_idx == CW'(k)) word[k] = serial_data_in;
        end
        word_done = enable && (bit_cnt_q == LAST_BIT);
        if (!enable || word_done) begin
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

endmodule

// File: rtl/nv_deserializer.sv
// Serial-to-parallel receiver with ready/valid output register and sticky
// frame-error / overrun flags.
//   state | meaning
//   IDLE  | no partial word held; next enabled edge samples bit 0
//   SHIFT | partial word held; enable low here is a truncated frame
module nv_deserializer
    import nv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = NV_DATA_WIDTH,
    parameter int LSB_FIRST  = NV_LSB_FIRST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  serial_data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overrun,
    input  logic                  clear_err
);

    rx_state_t             state_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;
    logic                  busy_q;
    logic                  frame_error_q;
    logic                  overrun_q;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] word;

    nv_rx_shift_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .serial_data_in(serial_data_in),
        .word_done     (word_done),
        .word          (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // High for every cycle following a sampled bit, so back-to-back words never dip
            busy_q <= enable;
            if (clear_err) begin
                frame_error_q <= 1'b0;
                overrun_q     <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (enable) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (!enable) begin
                        state_q       <= IDLE;
                        frame_error_q <= 1'b1;
                    end else if (word_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (word_done) begin
                if (!data_valid_q || data_ready) begin
                    data_out_q   <= word;
                    data_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (data_valid_q && data_ready) begin
                data_valid_q <= 1'b0;
            end
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign busy        = busy_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule
